// File: rtl/fir_stim_pkg.sv
// Shared definitions for the FIR stimulus generator:
// mode and FSM encodings, LFSR taps and the LFSR step rule.
package fir_stim_pkg;

    localparam int WIDTH_DEF = 24;
    localparam logic [23:0] LFSR_TAPS = 24'hE10000;

    typedef enum logic [1:0] {
        MODE_IMPULSE = 2'd0,
        MODE_STEP    = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_LFSR    = 2'd3
    } mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Galois form, taps 24/23/22/17
    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/fir_stim_lfsr.sv
// 24-bit Galois LFSR with synchronous seed load and
// per-strobe advance; cleared asynchronously by reset.
module fir_stim_lfsr
    import fir_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] seed,
    input  logic        advance,
    output logic [23:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/fir_stim_gen.sv
// Sample source for the FIR test socket: impulse, step,
// ramp and LFSR noise at one strobe every DIV cycles.
module fir_stim_gen
    import fir_stim_pkg::*;
#(
    parameter int          WIDTH     = WIDTH_DEF,
    parameter int          DIV       = 64,
    parameter logic [23:0] LFSR_SEED = 24'hACE123
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [15:0]      length,
    input  logic [WIDTH-1:0] amplitude,
    output logic [WIDTH-1:0] input_sig,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      sample_cnt
);

    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [DW-1:0]    div_cnt;
    mode_t            mode_q;
    logic [15:0]      len_q;
    logic [WIDTH-1:0] amp_q;
    logic [WIDTH-1:0] acc;
    logic             end_req;
    logic [23:0]      lfsr_state;
    logic [WIDTH-1:0] lfsr_w;
    logic [WIDTH-1:0] sample;
    logic             accept;
    logic             strobe;
    logic             last;

    assign accept = (state == S_IDLE) && start;
    assign strobe = (state == S_RUN) && !end_req
                    && (div_cnt == DIV_LAST);
    assign last   = strobe && (len_q != 16'd0)
                    && (sample_cnt + 16'd1 == len_q);
    assign busy   = (state == S_RUN);

    fir_stim_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .seed    (LFSR_SEED),
        .advance (strobe),
        .state   (lfsr_state)
    );

    generate
        if (WIDTH > 24) begin : g_ext
            assign lfsr_w = {{(WIDTH-24){lfsr_state[23]}}, lfsr_state};
        end else if (WIDTH == 24) begin : g_eq
            assign lfsr_w = lfsr_state;
        end else begin : g_trunc
            assign lfsr_w = lfsr_state[WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        sample = '0;
        unique case (mode_q)
            MODE_IMPULSE: sample = (sample_cnt == 16'd0) ? amp_q : '0;
            MODE_STEP:    sample = amp_q;
            MODE_RAMP:    sample = acc;
            MODE_LFSR:    sample = lfsr_w;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN:  if (end_req) state_nxt = S_IDLE;
        endcase
    end

    // end_req defers the end sequence by one edge so the last
    // strobe (or a strobe coinciding with stop) is still issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            mode_q     <= MODE_IMPULSE;
            len_q      <= '0;
            amp_q      <= '0;
            acc        <= '0;
            end_req    <= 1'b0;
            input_sig  <= '0;
            ready      <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            ready <= 1'b0;
            done  <= 1'b0;
            if (accept) begin
                div_cnt    <= '0;
                sample_cnt <= '0;
                mode_q     <= mode_t'(mode);
                len_q      <= length;
                amp_q      <= amplitude;
                acc        <= '0;
                end_req    <= 1'b0;
            end else if (state == S_RUN) begin
                if (end_req) begin
                    done      <= 1'b1;
                    input_sig <= '0;
                    end_req   <= 1'b0;
                end else begin
                    div_cnt <= strobe ? '0 : div_cnt + DW'(1);
                    if (strobe) begin
                        ready      <= 1'b1;
                        input_sig  <= sample;
                        sample_cnt <= sample_cnt + 16'd1;
                        acc        <= acc + amp_q;
                    end
                    if (last || stop) begin
                        end_req <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_stim_gen.sv
// Scoreboard bench for fir_stim_gen: the driver queues expected
// samples and strobe cycles, a forked monitor checks each strobe.
module tb_fir_stim_gen;

    localparam int          W    = 24;
    localparam int          DIV  = 4;
    localparam logic [23:0] SEED = 24'h000001;

    typedef struct {
        logic [W-1:0] val;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic [1:0]   mode;
    logic [15:0]  length;
    logic [W-1:0] amplitude;
    logic [W-1:0] input_sig;
    logic         ready;
    logic         busy;
    logic         done;
    logic [15:0]  sample_cnt;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    fir_stim_gen #(
        .WIDTH     (W),
        .DIV       (DIV),
        .LFSR_SEED (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .length     (length),
        .amplitude  (amplitude),
        .input_sig  (input_sig),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample n straight from the waveform definitions
    function automatic logic [W-1:0] model(input int m, input int n,
                                           input logic [W-1:0] a);
        logic [23:0] s;
        case (m)
            0: return (n == 0) ? a : '0;
            1: return a;
            2: return W'(longint'(n) * longint'($signed(a)));
            default: begin
                s = SEED;
                for (int i = 0; i < n; i++)
                    s = s[0] ? ((s >> 1) ^ 24'hE10000) : (s >> 1);
                return s;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: cycle %0d sample 0x%0h, none required",
                             cyc, input_sig);
                end else begin
                    e = sb.pop_front();
                    check("sample", input_sig, e.val);
                    check("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    // Call at a negedge; returns #1 after the accepting edge
    task automatic launch(input int m, input int len,
                          input logic [W-1:0] a, input int n_exp,
                          output int c0);
        start     = 1'b1;
        mode      = 2'(m);
        length    = 16'(len);
        amplitude = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
        check("busy_rise", busy, 1);
        for (int k = 0; k < n_exp; k++)
            sb.push_back('{model(m, k, a), c0 + (k + 1) * DIV});
    endtask

    task automatic wait_done(input string name, input int exp_cyc,
                             input int exp_cnt, input bit chain,
                             output int seen);
        seen = -1;
        for (int i = 0; i < 300 && seen < 0; i++) begin
            @(negedge clk);
            if (done) seen = cyc;
        end
        check({name, "_done_cycle"}, seen, exp_cyc);
        if (seen >= 0) begin
            check({name, "_busy_low"}, busy, 0);
            check({name, "_sample_cnt"}, sample_cnt, exp_cnt);
            check({name, "_sig_zero"}, input_sig, 0);
            if (!chain) begin
                @(negedge clk);
                check({name, "_done_single"}, done, 0);
            end
        end
    endtask

    initial begin
        int c0;
        int c1;
        int dc;
        int d;
        int m;
        int len;
        logic [W-1:0] a;

        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        mode = 2'd0;
        length = 16'd0;
        amplitude = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("rst_sig", input_sig, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", sample_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        launch(0, 3, 24'd1000, 3, c0);
        wait_done("impulse", c0 + 3 * DIV + 1, 3, 1'b0, dc);

        launch(2, 3, 24'h400000, 3, c0);
        wait_done("ramp", c0 + 3 * DIV + 1, 3, 1'b0, dc);

        repeat (2) begin
            launch(3, 3, '0, 3, c0);
            wait_done("lfsr", c0 + 3 * DIV + 1, 3, 1'b0, dc);
        end

        // stop lands so the end edge is where strobe 6 would be
        d = DIV - 2;
        launch(1, 0, 24'd77, 5, c0);
        repeat (5 * DIV + d + 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("stop_edge", c0 + 5 * DIV + d + 2, 5, 1'b0, dc);

        d = $urandom_range(0, DIV - 2);
        launch(3, 0, '0, 5, c0);
        repeat (5 * DIV + d + 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("stop_rand", c0 + 5 * DIV + d + 2, 5, 1'b0, dc);

        // stop seen on the same edge as the last strobe
        launch(2, 3, 24'd9, 3, c0);
        repeat (3 * DIV) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("stop_last", c0 + 3 * DIV + 1, 3, 1'b0, dc);

        launch(1, 4, -24'sd5, 4, c0);
        repeat (DIV + 2) @(negedge clk);
        start = 1'b1;
        mode = 2'd2;
        length = 16'd9;
        amplitude = 24'd123;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", c0 + 4 * DIV + 1, 4, 1'b1, dc);
        launch(0, 2, 24'd55, 2, c1);
        check("restart_latency", c1, dc + 1);
        wait_done("restart", c1 + 2 * DIV + 1, 2, 1'b0, dc);

        launch(2, 6, 24'd3, 2, c0);
        repeat (2 * DIV + 2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_sig", input_sig, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cnt", sample_cnt, 0);
        check("mid_rst_sb", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(3, 3, '0, 3, c0);
        wait_done("post_rst", c0 + 3 * DIV + 1, 3, 1'b0, dc);

        for (int i = 0; i < 10; i++) begin
            m = $urandom_range(0, 3);
            len = $urandom_range(1, 6);
            a = W'($urandom);
            launch(m, len, a, len, c0);
            wait_done("rand", c0 + len * DIV + 1, len, 1'b0, dc);
        end

        repeat (2 * DIV) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_stim_gen.md
# fir_stim_gen

Sample source for the FIR filter test socket. It produces a sample stream on `input_sig` with a one-cycle `ready` strobe at a fixed divided rate. Waveform modes are impulse, step, ramp and LFSR noise. It sits directly upstream of the socket and drives the direct-form and separable FIR banks with identical stimulus, in bursts or free-running.

## Interface
- `WIDTH`, 24: sample width, signed two's complement.
- `DIV`, 64: clock cycles per sample. Must be at least 2.
- `LFSR_SEED`, 24'hACE123: LFSR reload value. Must be non-zero.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin burst. Sampled only in IDLE.
- `stop`  in  1  abort burst. Sampled only in RUN.
- `mode`  in  2  waveform: 0 impulse, 1 step, 2 ramp, 3 lfsr. Latched on accepted start.
- `length`  in  16  samples per burst. 0 means free-run until `stop`. Latched on accepted start.
- `amplitude`  in  WIDTH  signed amplitude or ramp increment. Latched on accepted start.
- `input_sig`  out  WIDTH  signed sample. Registered.
- `ready`  out  1  one-cycle strobe marking a new sample on `input_sig`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at burst end.
- `sample_cnt`  out  16  strobes issued in the current or last burst.

## Operation
- FSM has two states, IDLE and RUN. Reset enters IDLE.
- **IDLE → RUN** on `start`. In the same edge:
  - clear the divider and `sample_cnt`;
  - latch `mode`, `length` and `amplitude`;
  - reload the LFSR with `LFSR_SEED`;
  - clear the ramp accumulator.
- **RUN → IDLE**, whichever comes first:
  - the edge issuing strobe number `length` when `length` ≠ 0;
  - the edge after `stop` is seen high.
- `start` in RUN is ignored. `stop` in IDLE is ignored.
- Sample n (n = 0, 1, …) depends on mode:
  - impulse: A for n = 0, else 0.
  - step: A.
  - ramp: n·A, modulo 2^WIDTH. Wraps silently, no saturation.
  - lfsr: the 24-bit state, sign-extended or truncated to WIDTH.
    - Sample 0 is the seed.
    - The state advances once per strobe as a Galois LFSR: if bit0 is 1, state = (state>>1) ^ 24'hE10000; else state>>1. Taps are 24, 23, 22, 17.
- `sample_cnt` increments with each strobe and wraps at 65535→0 in free-run. It holds its value in IDLE until the next start.

## Timing
- **Reset values:** `input_sig`=0, `ready`=0, `busy`=0, `done`=0, `sample_cnt`=0. The divider, accumulator and LFSR are cleared asynchronously, and the FSM returns to IDLE mid-burst with no `done`.
- **`busy`** rises on the edge that accepts `start`.
- **First strobe:** `ready` is high for the cycle beginning DIV edges after the accepting edge. Later strobes come every DIV cycles.
- **Sample update:** `input_sig` changes only on the edge that raises `ready` and holds until the next strobe.
- **Burst end by length:** the edge raising the last `ready` does not drop `busy`. On the following edge:
  - `busy` falls;
  - `done` pulses for one cycle;
  - `input_sig` returns to 0.
- **Burst end by stop:** on the edge after `stop`, `busy` falls, `done` pulses and `input_sig` returns to 0. No further strobe is issued, even if the divider was at DIV-1.
- **`stop` and the last strobe on the same edge:** the strobe is issued, and the end sequence happens once.
- **Restart latency:** a `start` in the cycle `done` is high is accepted, giving back-to-back bursts with one idle cycle between them.

## Structure
- Shared package `fir_stim_pkg` holds:
  - the WIDTH default;
  - the mode encodings;
  - the FSM state encoding;
  - the LFSR tap mask 24'hE10000.
- One sub-module, `fir_stim_lfsr`: 24-bit Galois LFSR with `load`/`seed`/`advance` inputs and `state` output.
- The divider, ramp accumulator and FSM live in `fir_stim_gen`.

## Test plan
- **Impulse:** DIV=4, A=1000, length=3. Required: `ready` at cycles 4, 8 and 12 after the accepting edge, samples 1000, 0, 0. `done` and `busy` fall one cycle after the third strobe, `sample_cnt`=3, `input_sig`=0.
- **Ramp wrap:** A=24'h400000, length=3. Required: samples 0, 4194304, then -8388608.
- **LFSR:** `LFSR_SEED`=1, length=3. Required: samples 1, 24'hE10000 (-2031616), 24'h708000 (7372800). The sequence repeats identically on the next burst.
- **Free-run with stop:** length=0, `stop` asserted after the 5th strobe. Required: no 6th strobe, one `done` pulse, `sample_cnt`=5.
- **Start while busy:** step A=-5, `start` pulsed again mid-burst. Required: the start is ignored and every sample is -5. A `start` during `done` is accepted.
- **Reset mid-burst:** `rst` between strobes. Required: all outputs 0 at once, no `done`. A subsequent start behaves as from power-up.
